// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the data path (master) and the UART transmitter (slave).
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid;
    logic                  ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small circular FIFO.
// Frames leave back-to-back whenever the FIFO holds data at the end of a stop bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_if.slave                 bus,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [1:0]            state_r;
    logic [BAUD_W-1:0]     baud_r;
    logic [IDX_W-1:0]      bit_idx_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  uart_tx_r;
    logic                  busy_r;

    logic ready_s;
    logic push_s;
    logic pop_s;
    logic bit_end_s;
    logic fifo_empty_s;
    logic tx_next_s;

    assign ready_s      = (count_r != CNT_FULL);
    assign push_s       = bus.valid && ready_s && !reset;
    assign bit_end_s    = (baud_r == BAUD_LAST);
    assign fifo_empty_s = (count_r == CNT_W'(0));

    assign bus.ready  = ready_s;
    assign uart_tx    = uart_tx_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;

    // Pop decision: only from IDLE, or at the last cycle of a stop bit for a gapless next frame.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end_s && !fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Line level for the next cycle, derived from the current FSM state.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_r)
            ST_IDLE:  tx_next_s = 1'b1;
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shift_r[0];
            ST_STOP:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.data_in;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer: start bit, DATA_WIDTH data bits LSB first, stop bit, each CLKS_PER_BIT long.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_W'(0);
            bit_idx_r <= IDX_W'(0);
            shift_r   <= DATA_WIDTH'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        state_r <= ST_START;
                        baud_r  <= BAUD_W'(0);
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_r    <= BAUD_W'(0);
                        bit_idx_r <= IDX_W'(0);
                        state_r   <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_r  <= BAUD_W'(0);
                        shift_r <= shift_r >> 1;
                        if (bit_idx_r == IDX_LAST) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_r <= BAUD_W'(0);
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= BAUD_W'(0);
                end
            endcase
        end
    end

    // Registered pin drivers so the TX line never glitches on state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            uart_tx_r <= tx_next_s;
            busy_r    <= (state_r != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at CLKS_PER_BIT=4.
// The reference model schedules every accepted byte as a frame window in time:
// a byte pushed at edge N is popped at max(N+1, previous_pop+FRAME) and occupies
// the line from the edge after its pop for FRAME cycles.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int             t = 0;
    int             last_pop = -1000;
    int             checks = 0;
    int             failures = 0;
    int             push_t[$];
    int             pop_t[$];
    int             end_t[$];
    logic [DW-1:0]  dat[$];

    // Entries buffered as seen just after edge 'at'.
    function automatic int model_count(input int at);
        int c;
        c = 0;
        foreach (push_t[i]) begin
            if (push_t[i] <= at && pop_t[i] > at) c++;
        end
        return c;
    endfunction

    // {busy, uart_tx} expected just after edge 'at'.
    function automatic logic [1:0] model_line(input int at);
        int            k;
        logic [DW-1:0] b;
        foreach (pop_t[i]) begin
            if (at >= pop_t[i] + 1 && at <= end_t[i]) begin
                k = (at - pop_t[i] - 1) / CPB;
                b = dat[i];
                if (k == 0) return 2'b10;
                else if (k <= DW) return {1'b1, b[k-1]};
                else return 2'b11;
            end
        end
        return 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model at the edge, check all outputs after it.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int         p;
        logic [1:0] line;
        int         cnt;
        bus.valid   = v;
        bus.data_in = d;
        reset       = r;
        @(posedge clk);
        t++;
        if (r) begin
            for (int i = pop_t.size() - 1; i >= 0; i--) begin
                if (pop_t[i] >= t) begin
                    push_t.delete(i);
                    pop_t.delete(i);
                    end_t.delete(i);
                    dat.delete(i);
                end
            end
            foreach (end_t[i]) begin
                if (end_t[i] > t - 1) end_t[i] = t - 1;
            end
            last_pop = t - FRAME;
        end else if (v && model_count(t - 1) < DEPTH) begin
            p = (t + 1 > last_pop + FRAME) ? t + 1 : last_pop + FRAME;
            push_t.push_back(t);
            pop_t.push_back(p);
            end_t.push_back(p + FRAME);
            dat.push_back(d);
            last_pop = p;
        end
        #1;
        line = model_line(t);
        cnt  = model_count(t);
        chk("uart_tx", {7'd0, uart_tx}, {7'd0, line[0]});
        chk("busy", {7'd0, busy}, {7'd0, line[1]});
        chk("fifo_count", {5'd0, fifo_count}, 8'(cnt));
        chk("ready", {7'd0, bus.ready}, {7'd0, (cnt != DEPTH)});
    endtask

    initial begin
        int p0;
        bus.valid   = 1'b0;
        bus.data_in = 8'h00;
        reset       = 1'b1;

        // Reset state
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Single byte 0xA5 from idle
        step(1'b1, 8'hA5, 1'b0);
        repeat (45) step(1'b0, 8'h00, 1'b0);

        // Two bytes on consecutive cycles -> contiguous frames
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        repeat (90) step(1'b0, 8'h00, 1'b0);

        // Hold valid for six cycles: FIFO fills, last byte dropped
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        repeat (210) step(1'b0, 8'h00, 1'b0);

        // Reset in the middle of frame 1 with bytes queued; valid ignored during reset
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        repeat (15) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h99, 1'b1);
        repeat (60) step(1'b0, 8'h00, 1'b0);

        // Push on the exact edge a stop bit ends with an empty FIFO
        step(1'b1, 8'h5A, 1'b0);
        p0 = last_pop;
        while (t < p0 + FRAME - 1) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0);

        // Push one edge earlier: next frame follows with no gap
        step(1'b1, 8'h81, 1'b0);
        p0 = last_pop;
        while (t < p0 + FRAME - 2) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h7E, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0);

        // Randomized traffic with rare resets
        repeat (700) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 249) == 0));
        end
        repeat (220) step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
